// File: rtl/systolic_result_drain_if.sv
// Valid/ready element stream from the result drain to its consumer,
// carrying each element with its row/column tags and an end-of-frame flag.
interface systolic_result_drain_if #(
    parameter int W  = 4,
    parameter int IW = 2
);
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [IW-1:0] m_row;
    logic [IW-1:0] m_col;
    logic          m_last;

    modport master (
        output m_valid, m_data, m_row, m_col, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_row, m_col, m_last,
        output m_ready
    );
endinterface

// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array's N x N result on its done pulse and streams it
// out row-major, one element per handshake, freeing the array immediately.
module systolic_result_drain #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [W-1:0]          res_i [N][N],
    input  logic                  done_i,
    systolic_result_drain_if.master m_if,
    output logic                  busy_o,
    output logic                  overrun_o,
    input  logic                  ovr_clr_i,
    output logic [7:0]            frame_cnt_o
);

    typedef enum logic {IDLE, DRAIN} state_e;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] row_q, row_d, col_q, col_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [W-1:0]  snap_q [N][N];
    logic [W-1:0]  snap_d [N][N];
    logic          capture, overrun_set, xfer, at_last;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        frame_cnt_d = frame_cnt_q;
        capture     = 1'b0;
        overrun_set = 1'b0;
        at_last     = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        xfer        = (state_q == DRAIN) && m_if.m_ready;

        case (state_q)
            IDLE: begin
                if (done_i) begin
                    capture = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (at_last) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        row_d       = '0;
                        col_d       = '0;
                        // A done on the final handshake chains the next frame with no bubble.
                        if (done_i) capture = 1'b1;
                        else        state_d = IDLE;
                    end else if (col_q == LAST_IDX) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (done_i && !(xfer && at_last)) overrun_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        overrun_d = overrun_set | (overrun_q & ~ovr_clr_i);

        snap_d = snap_q;
        if (capture) snap_d = res_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // NOTE: the snapshot buffer has no reset; it is always written before being read,
    // and leaving it out of reset keeps it plain storage.
    always_ff @(posedge clk_i) begin
        snap_q <= snap_d;
    end

    always_comb begin
        m_if.m_valid = (state_q == DRAIN);
        m_if.m_data  = '0;
        m_if.m_row   = '0;
        m_if.m_col   = '0;
        m_if.m_last  = 1'b0;
        if (state_q == DRAIN) begin
            m_if.m_data = snap_q[row_q][col_q];
            m_if.m_row  = row_q;
            m_if.m_col  = col_q;
            m_if.m_last = at_last;
        end
    end

    assign busy_o      = (state_q == DRAIN);
    assign overrun_o   = overrun_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain (N=4, W=4): expected elements are
// queued at each accepted done pulse and popped on every observed transfer.
module tb_systolic_result_drain;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] res [4][4];
  logic       done;
  logic       ovr_clr;
  logic       busy;
  logic       overrun;
  logic [7:0] frame_cnt;

  exp_t       sb[$];
  logic [7:0] exp_frames;
  logic       exp_overrun;
  int         tests_run = 0;
  int         fails = 0;

  systolic_result_drain_if #(.W(4), .IW(2)) m_if ();

  systolic_result_drain #(.N(4), .W(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .res_i       (res),
    .done_i      (done),
    .m_if        (m_if),
    .busy_o      (busy),
    .overrun_o   (overrun),
    .ovr_clr_i   (ovr_clr),
    .frame_cnt_o (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        res[i][j] = 4'((4 * i + j) & 15);
  endtask

  task automatic set_all(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        res[i][j] = v;
  endtask

  task automatic set_random();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        res[i][j] = 4'($urandom_range(0, 15));
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        e.data = res[i][j];
        e.row  = 2'(i);
        e.col  = 2'(j);
        e.last = (i == 3) && (j == 3);
        sb.push_back(e);
      end
  endtask

  // Pulse done from IDLE with the current res matrix.
  task automatic start_frame();
    done = 1'b1;
    push_frame();
    step();
    done = 1'b0;
  endtask

  // Drains until the scoreboard is empty. ready_mode: 0 always, 1 pattern 1,0,0, 2 random.
  // At transfer number inject_idx, pulses done with all-inject_val; inject_ok says the
  // pulse is expected to be accepted (back-to-back) rather than dropped as an overrun.
  task automatic run_drain(input int ready_mode, input int inject_idx,
                           input logic [3:0] inject_val, input bit inject_ok,
                           input bit scramble);
    int         xfers = 0;
    int         cyc = 0;
    bit         prev_stall = 1'b0;
    logic [8:0] saved;
    exp_t       e;
    while (sb.size() > 0 && cyc < 2000) begin
      tests_run++;
      if (m_if.m_valid !== 1'b1) begin
        fails++;
        $display("FAIL valid_held: got %b expected 1 (xfer %0d)", m_if.m_valid, xfers);
      end
      if (prev_stall) begin
        tests_run++;
        if ({m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last} !== saved) begin
          fails++;
          $display("FAIL stall_stable: got %h expected %h", {m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last}, saved);
        end
      end
      case (ready_mode)
        0:       m_if.m_ready = 1'b1;
        1:       m_if.m_ready = (cyc % 3 == 0);
        default: m_if.m_ready = 1'($urandom_range(0, 1));
      endcase
      done = 1'b0;
      if (scramble) set_random();
      if (m_if.m_valid && m_if.m_ready) begin
        e = sb.pop_front();
        tests_run++;
        if ({m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last} !== e) begin
          fails++;
          $display("FAIL xfer: got data=%h row=%0d col=%0d last=%b expected data=%h row=%0d col=%0d last=%b",
                   m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last, e.data, e.row, e.col, e.last);
        end
        if (e.last) exp_frames = exp_frames + 8'd1;
        if (xfers == inject_idx) begin
          done = 1'b1;
          set_all(inject_val);
          if (inject_ok) push_frame();
          else           exp_overrun = 1'b1;
        end
        xfers++;
      end
      prev_stall = m_if.m_valid && !m_if.m_ready;
      saved = {m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last};
      step();
      cyc++;
    end
    done = 1'b0;
    m_if.m_ready = 1'b0;
    if (sb.size() > 0) begin
      tests_run++;
      fails++;
      $display("FAIL drain_timeout: got %0d elements left expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_idle_after(input string name);
    tests_run++;
    if ({busy, m_if.m_valid, frame_cnt, overrun} !== {1'b0, 1'b0, exp_frames, exp_overrun}) begin
      fails++;
      $display("FAIL %s_idle: got busy=%b valid=%b frames=%0d ovr=%b expected busy=0 valid=0 frames=%0d ovr=%b",
               name, busy, m_if.m_valid, frame_cnt, overrun, exp_frames, exp_overrun);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    exp_frames  = 8'd0;
    exp_overrun = 1'b0;
    tests_run++;
    if ({m_if.m_valid, m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last, busy, overrun, frame_cnt} !== 20'd0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b data=%h row=%0d col=%0d last=%b busy=%b ovr=%b frames=%0d expected all 0",
               m_if.m_valid, m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last, busy, overrun, frame_cnt);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_ramp();
    start_frame();
    tests_run++;
    if ({m_if.m_valid, m_if.m_data, m_if.m_row, m_if.m_col, busy} !== {1'b1, 4'h0, 2'd0, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL first_latency: got valid=%b data=%h row=%0d col=%0d busy=%b expected 1 0 0 0 1",
               m_if.m_valid, m_if.m_data, m_if.m_row, m_if.m_col, busy);
    end
    run_drain(0, -1, 4'h0, 1'b0, 1'b0);
    check_idle_after("basic");
  endtask

  task automatic test_stall();
    set_ramp();
    start_frame();
    run_drain(1, -1, 4'h0, 1'b0, 1'b0);
    check_idle_after("stall");
  endtask

  task automatic test_overrun();
    set_ramp();
    start_frame();
    run_drain(0, 5, 4'hA, 1'b0, 1'b0);
    check_idle_after("overrun");
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    exp_overrun = 1'b0;
    tests_run++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clear: got %b expected 0", overrun);
    end
    // Overrun set and clear in the same cycle: set must win.
    set_ramp();
    start_frame();
    m_if.m_ready = 1'b0;
    done = 1'b1;
    ovr_clr = 1'b1;
    step();
    done = 1'b0;
    ovr_clr = 1'b0;
    exp_overrun = 1'b1;
    tests_run++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_set_wins: got %b expected 1", overrun);
    end
    run_drain(0, -1, 4'h0, 1'b0, 1'b0);
    check_idle_after("ovr_set_wins");
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_ramp();
    start_frame();
    run_drain(0, 15, 4'h3, 1'b1, 1'b0);
    check_idle_after("back_to_back");
  endtask

  task automatic test_snapshot();
    set_random();
    start_frame();
    run_drain(2, -1, 4'h0, 1'b0, 1'b1);
    check_idle_after("snapshot");
  endtask

  task automatic test_reset_mid();
    set_ramp();
    start_frame();
    sb.delete();
    m_if.m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (m_if.m_data !== 4'(k)) begin
        fails++;
        $display("FAIL mid_data: got %h expected %h", m_if.m_data, 4'(k));
      end
      if (k < 7) step();
    end
    rst_n = 1'b0;
    m_if.m_ready = 1'b0;
    step();
    rst_n = 1'b1;
    exp_frames  = 8'd0;
    exp_overrun = 1'b0;
    check_idle_after("reset_mid");
    set_ramp();
    start_frame();
    run_drain(0, -1, 4'h0, 1'b0, 1'b0);
    check_idle_after("after_reset_mid");
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_frames  = 8'd0;
    exp_overrun = 1'b0;
    for (int f = 0; f < 256; f++) begin
      set_random();
      start_frame();
      run_drain(0, -1, 4'h0, 1'b0, 1'b0);
      if (f == 254) begin
        tests_run++;
        if (frame_cnt !== 8'd255) begin
          fails++;
          $display("FAIL wrap_255: got %0d expected 255", frame_cnt);
        end
      end
    end
    tests_run++;
    if (frame_cnt !== 8'd0) begin
      fails++;
      $display("FAIL wrap_zero: got %0d expected 0", frame_cnt);
    end
    check_idle_after("wrap");
  endtask

  initial begin
    rst_n        = 1'b0;
    done         = 1'b0;
    ovr_clr      = 1'b0;
    m_if.m_ready = 1'b0;
    exp_frames   = 8'd0;
    exp_overrun  = 1'b0;
    set_all(4'h0);
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_snapshot();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
